alu_mul_seq: RTL and testbench
==============================

Name: alu_mul_seq

Overview:
- Multi-cycle unsigned shift-add multiplier sequencer. It produces the low WIDTH bits of op_a*op_b, which are also correct for two's-complement operands.
- It owns no adder. Each partial-product add is done on the shared pipeline ALU through a request/grant handshake.
- It sits beside the EX stage. The EX stage keeps priority on the ALU and grants it to this block only on cycles it leaves free.

Parameters:
- WIDTH, 32, operand and result width; must match the ALU datapath width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a multiply; accepted only in IDLE.
- op_a  input  WIDTH  multiplicand; sampled on the accepted start.
- op_b  input  WIDTH  multiplier; sampled on the accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result is valid from this cycle.
- result  output  WIDTH  low WIDTH bits of the product; held until the next accepted start.
- alu_req  output  1  this block needs the ALU this cycle.
- alu_gnt  input  1  the EX stage grants the ALU this cycle (combinational to alu_out).
- alu_a  output  WIDTH  ALU operand A.
- alu_b  output  WIDTH  ALU operand B.
- alu_ctrl  output  3  ALU operation select.
- alu_out  input  WIDTH  ALU result, combinational from alu_a/alu_b/alu_ctrl.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy, done, alu_req =0.
  - result, alu_a, alu_b, alu_ctrl =0.
  - Internal acc, mcand, mplier =0.
  - Reset during RUN or DONE aborts the operation; no done pulse follows.
- State register: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches mcand<=op_a, mplier<=op_b, acc<=0, then go to RUN.
  - start=0 stays in IDLE.
- RUN, evaluated every cycle:
  - mplier==0: go to DONE; no ALU request.
  - mplier[0]==1:
    - Assert alu_req with alu_a=acc, alu_b=mcand, alu_ctrl=ALU_ADD.
    - If alu_gnt=1: acc<=alu_out, mcand<=mcand<<1, mplier<=mplier>>1.
    - If alu_gnt=0 (stall): all state holds and the request repeats next cycle with identical operands.
  - mplier[0]==0: no request; mcand<=mcand<<1, mplier<=mplier>>1, acc holds.
- DONE (one cycle): done=1, result<=acc (result is registered on entry to DONE), then go to IDLE.
- busy=1 in RUN and DONE.
- start while busy: ignored, with no effect on the in-flight operation.
- start is accepted no earlier than the cycle after DONE.
- When alu_req=0, alu_a, alu_b and alu_ctrl drive 0.
- alu_gnt while alu_req=0: ignored.
- Width rules:
  - Sum is truncated to WIDTH bits; carry is discarded.
  - mcand shifts left with zero fill; bits shifted out are lost.
  - mplier shifts right with zero fill.
- Latency, start accepted at cycle 0, no stalls, k = index of the highest set bit of op_b:
  - RUN covers cycles 1..k+1.
  - Zero is detected at cycle k+2.
  - done is high at cycle k+3.
  - op_b=0 gives done at cycle 2.
  - Worst case is k=WIDTH-1: done at cycle WIDTH+2.
  - Each denied grant adds exactly 1 cycle.
- Maximum RUN length is WIDTH productive iterations plus stalls, so no separate iteration counter is required.

Decomposition:
- Shared package alu_pkg: 3-bit ALU encodings ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b011, ALU_SLT=3'b100.
- The package also holds the state enum {IDLE, RUN, DONE}.
- No sub-module: one FSM with three datapath registers. Benches instantiate the existing ALU and tie alu_gnt as required.

Test Plan:
- op_a=7, op_b=6, alu_gnt=1 -> start@0; alu_req high only at cycles 2 and 3; done@5; result=42; busy high cycles 1..5.
- op_a=0x12345678, op_b=0 -> no alu_req; done@2; result=0.
- op_a=0xFFFFFFFD (-3), op_b=5 -> result=0xFFFFFFF1 (-15); done@5.
- op_a=0xFFFFFFFF, op_b=0xFFFFFFFF, alu_gnt=1 -> result=0x00000001; done@34.
- op_a=3, op_b=3, alu_gnt low for 2 cycles on the first request -> alu_a/alu_b stable while stalled; done@6; result=9.
- Mid-RUN checks:
  - Reset asserted during RUN -> outputs 0 immediately; no done.
  - Pulse start during RUN (0x10/0x2, sampled at 0x3/0x4) -> final result=0x20 from the first operands.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU operation encodings and the multiply sequencer state type.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier that borrows the pipeline ALU for each partial-product add.
// Returns the low WIDTH bits of op_a*op_b, valid for unsigned and two's-complement operands.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out
);

  state_e           state;
  state_e           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic             step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // An add step advances only when granted; an un-granted request holds all state
  // so the same operands are presented again on the next cycle.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    alu_req   = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_ctrl  = ALU_AND;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (mplier == '0) begin
          state_nxt = DONE;
        end else if (mplier[0]) begin
          alu_req  = 1'b1;
          alu_a    = acc;
          alu_b    = mcand;
          alu_ctrl = ALU_ADD;
          step     = alu_gnt;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      result <= '0;
    end else begin
      if (state == IDLE && start) begin
        mcand  <= op_a;
        mplier <= op_b;
        acc    <= '0;
      end else if (step) begin
        if (alu_req) acc <= alu_out;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
      // Result is captured as the FSM leaves RUN so it is already valid while done is high.
      if (state == RUN && state_nxt == DONE) begin
        result <= acc;
      end
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Randomized self-checking bench for alu_mul_seq with a behavioural ALU and
// an iteration-level model of the expected request schedule and product.
module tb_alu_mul_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         alu_req;
  logic         alu_gnt;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_ctrl;
  logic [W-1:0] alu_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_mul_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result),
    .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .alu_out(alu_out)
  );

  // Stand-in for the pipeline ALU.
  always_comb begin
    alu_out = '0;
    case (alu_ctrl)
      ALU_AND: alu_out = alu_a & alu_b;
      ALU_OR:  alu_out = alu_a | alu_b;
      ALU_ADD: alu_out = alu_a + alu_b;
      ALU_SUB: alu_out = alu_a - alu_b;
      ALU_SLT: alu_out = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      default: alu_out = '0;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs one multiply. The model walks multiplier bit positions: while bits
  // remain at or above position i, bit i decides whether an add of a<<i onto
  // a*(b mod 2^i) is requested; then one zero-detect cycle, then the done cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int deny_first, input bit rnd,
                        input int mid_cyc, output int dcyc);
    int           i;
    bit           zdet;
    int           denied;
    bit           g;
    logic [63:0]  rest;
    logic [63:0]  mask;
    logic [W-1:0] low_b;
    logic [W-1:0] e_acc;
    logic [W-1:0] e_mcand;
    logic [W-1:0] e_prod;
    e_prod = a * b;
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b;
    @(posedge clk);
    #1 start = 1'b0; op_a = $urandom; op_b = $urandom;
    i = 0; zdet = 0; denied = 0; dcyc = -1;
    for (int c = 1; c <= 400 && dcyc < 0; c++) begin
      @(negedge clk);
      rest = 64'(b) >> i;
      if (!zdet && rest != 64'd0) begin
        chk("run_busy", 64'(busy), 64'd1);
        chk("run_done", 64'(done), 64'd0);
        chk("run_req", 64'(alu_req), 64'(b[i]));
        if (b[i]) begin
          mask    = (64'd1 << i) - 64'd1;
          low_b   = W'(64'(b) & mask);
          e_acc   = a * low_b;
          e_mcand = a << i;
          chk("req_a", 64'(alu_a), 64'(e_acc));
          chk("req_b", 64'(alu_b), 64'(e_mcand));
          chk("req_ctrl", 64'(alu_ctrl), 64'(ALU_ADD));
          if (denied < deny_first) g = 1'b0;
          else if (rnd) g = ($urandom_range(0, 3) != 0);
          else g = 1'b1;
          if (!g) denied++;
          alu_gnt = g;
          if (g) i++;
        end else begin
          chk("idle_alu_a", 64'(alu_a), 64'd0);
          chk("idle_alu_ctrl", 64'(alu_ctrl), 64'd0);
          alu_gnt = $urandom_range(0, 1);
          i++;
        end
      end else if (!zdet) begin
        zdet = 1;
        chk("zero_busy", 64'(busy), 64'd1);
        chk("zero_req", 64'(alu_req), 64'd0);
        chk("zero_done", 64'(done), 64'd0);
        alu_gnt = $urandom_range(0, 1);
      end else begin
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd1);
        chk("done_result", 64'(result), 64'(e_prod));
        dcyc = c;
      end
      if (c == mid_cyc) begin
        start = 1'b1; op_a = 32'h3; op_b = 32'h4;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (dcyc < 0) begin
      bad++; total++;
      $display("FAIL timeout: no done for a=0x%0h b=0x%0h", a, b);
    end
    @(negedge clk);
    chk("after_busy", 64'(busy), 64'd0);
    chk("after_done", 64'(done), 64'd0);
    chk("after_hold", 64'(result), 64'(e_prod));
  endtask

  initial begin
    int dc;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; alu_gnt = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_req", 64'(alu_req), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_alu_b", 64'(alu_b), 64'd0);
    rst = 1'b0;

    run_op(32'd7, 32'd6, 0, 0, 0, dc);
    chk("t1_done_cyc", 64'(dc), 64'd5);
    chk("t1_result", 64'(result), 64'd42);

    run_op(32'h12345678, 32'd0, 0, 0, 0, dc);
    chk("t2_done_cyc", 64'(dc), 64'd2);
    chk("t2_result", 64'(result), 64'd0);

    run_op(32'hFFFFFFFD, 32'd5, 0, 0, 0, dc);
    chk("t3_done_cyc", 64'(dc), 64'd5);
    chk("t3_result", 64'(result), 64'hFFFFFFF1);

    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, dc);
    chk("t4_done_cyc", 64'(dc), 64'd34);
    chk("t4_result", 64'(result), 64'd1);

    run_op(32'd3, 32'd3, 2, 0, 0, dc);
    chk("t5_done_cyc", 64'(dc), 64'd6);
    chk("t5_result", 64'(result), 64'd9);

    run_op(32'h10, 32'h2, 0, 0, 2, dc);
    chk("t6_done_cyc", 64'(dc), 64'd4);
    chk("t6_result", 64'(result), 64'h20);

    // Abort mid-RUN with an asynchronous reset.
    @(negedge clk);
    start = 1'b1; op_a = 32'd5; op_b = 32'hFF; alu_gnt = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_req", 64'(alu_req), 64'd0);
    chk("abort_alu_a", 64'(alu_a), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk("abort_no_done", 64'(done), 64'd0);
      chk("abort_idle", 64'(busy), 64'd0);
    end

    for (int n = 0; n < 25; n++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      run_op(ra, rb, $urandom_range(0, 1), 1, 0, dc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
